mem_port_arbiter: RTL and testbench

Shares the single MIG user port (command + write FIFO + read FIFO) between two requesters: requester 0, the SD-card boot loader, and requester 1, the CPU/GPU memory client. It serialises single-word read and write transactions with round-robin arbitration. It holds off all traffic until memory calibration completes. It sits between the requester blocks and the MIG port in the top level.

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/mem_port_arbiter_rr_arbiter2.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the MIG user-port arbiter: FSM states and MIG command codes.
package mem_port_arbiter_pkg;

  // MIG command encodings for the cmd_instr field.
  localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
  localparam logic [2:0] MIG_CMD_READ  = 3'b001;

  // Every transaction is a single 32-bit word.
  localparam logic [5:0] MIG_BL_SINGLE = 6'd0;

  // Requester 1 counts as the last one granted out of reset, so requester 0 wins the first tie.
  localparam logic LAST_GRANT_RESET = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_WR_CMD,
    ST_RD_CMD,
    ST_RD_WAIT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter. It owns the last-grant history used to break ties.
module rr_arbiter2
  import mem_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       enable_i,
  input  logic       update_i,
  output logic [1:0] grant_o
);

  logic last_grant_q;
  logic last_grant_d;

  // Grant a lone requester directly. On a tie, grant the requester that was not granted last.
  always_comb begin
    grant_o = 2'b00;
    if (enable_i) begin
      unique case (req_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = last_grant_q ? 2'b01 : 2'b10;
        default: grant_o = 2'b00;
      endcase
    end
  end

  // Record the winner only when a grant is actually taken.
  always_comb begin
    last_grant_d = last_grant_q;
    if (update_i) begin
      last_grant_d = grant_o[1];
    end
  end

  // Last-grant history register.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= LAST_GRANT_RESET;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one MIG user port between the SD boot loader (r0) and the CPU/GPU client (r1).
// Transactions are single-word reads or writes, serialised with round-robin arbitration.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              calib_done,

  input  logic              r0_req,
  output logic              r0_ready,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [31:0]       r0_wdata,
  input  logic [3:0]        r0_mask,
  output logic              r0_done,
  output logic [31:0]       r0_rdata,

  input  logic              r1_req,
  output logic              r1_ready,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [31:0]       r1_wdata,
  input  logic [3:0]        r1_mask,
  output logic              r1_done,
  output logic [31:0]       r1_rdata,

  output logic              mem_cmd_en,
  output logic [2:0]        mem_cmd_instr,
  output logic [5:0]        mem_cmd_bl,
  output logic [ADDR_W-1:0] mem_cmd_byte_addr,
  input  logic              mem_cmd_full,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wr_data,
  output logic [3:0]        mem_wr_mask,
  input  logic              mem_wr_full,
  input  logic              mem_wr_error,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rd_data,
  input  logic              mem_rd_empty,
  input  logic              mem_rd_error,
  output logic              err
);

  localparam logic [ADDR_W-1:0] WORD_ALIGN = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        mask_q, mask_d;
  logic [31:0]       rdata0_q, rdata0_d;
  logic [31:0]       rdata1_q, rdata1_d;
  logic              err_q, err_d;

  logic [1:0]        grant;
  logic              arb_enable;
  logic              accept;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [3:0]        sel_mask;

  // Grants are only offered from IDLE with memory calibrated, and never while reset is held.
  assign arb_enable = (state_q == ST_IDLE) && calib_done && !rst;
  assign accept     = |grant;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    ({r1_req, r0_req}),
    .enable_i (arb_enable),
    .update_i (accept),
    .grant_o  (grant)
  );

  assign r0_ready = grant[0];
  assign r1_ready = grant[1];

  // Mux the winning requester's fields; the arbiter guarantees at most one grant bit.
  always_comb begin
    sel_we    = grant[1] ? r1_we    : r0_we;
    sel_addr  = grant[1] ? r1_addr  : r0_addr;
    sel_wdata = grant[1] ? r1_wdata : r0_wdata;
    sel_mask  = grant[1] ? r1_mask  : r0_mask;
  end

  // Next-state and MIG handshakes: data is pushed before the write command, reads wait for the pop.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    mask_d        = mask_q;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
    err_d         = err_q | mem_wr_error | mem_rd_error;
    mem_cmd_en    = 1'b0;
    mem_cmd_instr = MIG_CMD_WRITE;
    mem_wr_en     = 1'b0;
    mem_rd_en     = 1'b0;
    r0_done       = 1'b0;
    r1_done       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          owner_d = grant[1];
          addr_d  = sel_addr & WORD_ALIGN;
          wdata_d = sel_wdata;
          mask_d  = sel_mask;
          state_d = sel_we ? ST_WR_DATA : ST_RD_CMD;
        end
      end
      ST_WR_DATA: begin
        mem_wr_en = !mem_wr_full;
        if (!mem_wr_full) begin
          state_d = ST_WR_CMD;
        end
      end
      ST_WR_CMD: begin
        mem_cmd_en    = !mem_cmd_full;
        mem_cmd_instr = MIG_CMD_WRITE;
        if (!mem_cmd_full) begin
          state_d = ST_DONE;
        end
      end
      ST_RD_CMD: begin
        mem_cmd_en    = !mem_cmd_full;
        mem_cmd_instr = MIG_CMD_READ;
        if (!mem_cmd_full) begin
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        mem_rd_en = !mem_rd_empty;
        if (!mem_rd_empty) begin
          if (owner_q) begin
            rdata1_d = mem_rd_data;
          end else begin
            rdata0_d = mem_rd_data;
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        r0_done = !owner_q;
        r1_done = owner_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Latched transaction fields always drive the MIG data/address ports.
  always_comb begin
    mem_cmd_bl        = MIG_BL_SINGLE;
    mem_cmd_byte_addr = addr_q;
    mem_wr_data       = wdata_q;
    mem_wr_mask       = mask_q;
    r0_rdata          = rdata0_q;
    r1_rdata          = rdata1_q;
    err               = err_q;
  end

  // State and datapath registers; reset abandons any transaction without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mask_q   <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mask_q   <= mask_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a word-level memory model and the round-robin grant rule.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 30;

  logic              clk = 1'b0;
  logic              rst;
  logic              calib_done;
  logic              r0_req, r0_ready, r0_we, r0_done;
  logic [ADDR_W-1:0] r0_addr;
  logic [31:0]       r0_wdata, r0_rdata;
  logic [3:0]        r0_mask;
  logic              r1_req, r1_ready, r1_we, r1_done;
  logic [ADDR_W-1:0] r1_addr;
  logic [31:0]       r1_wdata, r1_rdata;
  logic [3:0]        r1_mask;
  logic              mem_cmd_en;
  logic [2:0]        mem_cmd_instr;
  logic [5:0]        mem_cmd_bl;
  logic [ADDR_W-1:0] mem_cmd_byte_addr;
  logic              mem_cmd_full;
  logic              mem_wr_en;
  logic [31:0]       mem_wr_data;
  logic [3:0]        mem_wr_mask;
  logic              mem_wr_full, mem_wr_error;
  logic              mem_rd_en;
  logic [31:0]       mem_rd_data;
  logic              mem_rd_empty, mem_rd_error;
  logic              err;

  // 100 MHz system clock.
  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .calib_done        (calib_done),
    .r0_req            (r0_req),
    .r0_ready          (r0_ready),
    .r0_we             (r0_we),
    .r0_addr           (r0_addr),
    .r0_wdata          (r0_wdata),
    .r0_mask           (r0_mask),
    .r0_done           (r0_done),
    .r0_rdata          (r0_rdata),
    .r1_req            (r1_req),
    .r1_ready          (r1_ready),
    .r1_we             (r1_we),
    .r1_addr           (r1_addr),
    .r1_wdata          (r1_wdata),
    .r1_mask           (r1_mask),
    .r1_done           (r1_done),
    .r1_rdata          (r1_rdata),
    .mem_cmd_en        (mem_cmd_en),
    .mem_cmd_instr     (mem_cmd_instr),
    .mem_cmd_bl        (mem_cmd_bl),
    .mem_cmd_byte_addr (mem_cmd_byte_addr),
    .mem_cmd_full      (mem_cmd_full),
    .mem_wr_en         (mem_wr_en),
    .mem_wr_data       (mem_wr_data),
    .mem_wr_mask       (mem_wr_mask),
    .mem_wr_full       (mem_wr_full),
    .mem_wr_error      (mem_wr_error),
    .mem_rd_en         (mem_rd_en),
    .mem_rd_data       (mem_rd_data),
    .mem_rd_empty      (mem_rd_empty),
    .mem_rd_error      (mem_rd_error),
    .err               (err)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  // Model state: word-addressed memory behind the MIG, tie-break history, last data returned.
  logic [31:0]       refMem [int unsigned];
  int                lastGrant;
  logic [31:0]       expRdata [2];

  // Requester-side stimulus fields.
  logic              fReq   [2];
  logic              fWe    [2];
  logic [ADDR_W-1:0] fAddr  [2];
  logic [31:0]       fData  [2];
  logic [3:0]        fMask  [2];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    r0_req   = fReq[0];  r1_req   = fReq[1];
    r0_we    = fWe[0];   r1_we    = fWe[1];
    r0_addr  = fAddr[0]; r1_addr  = fAddr[1];
    r0_wdata = fData[0]; r1_wdata = fData[1];
    r0_mask  = fMask[0]; r1_mask  = fMask[1];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomizeReq(input int r);
    fWe[r]   = 1'($urandom_range(0, 1));
    fAddr[r] = ADDR_W'($urandom_range(0, 63));
    fData[r] = $urandom;
    fMask[r] = 4'($urandom_range(0, 15));
  endtask

  task automatic resetDut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    lastGrant   = 1;
    expRdata[0] = 32'h0;
    expRdata[1] = 32'h0;
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_r0_ready"}, r0_ready, 0);
    checkOutput({tag, "_r1_ready"}, r1_ready, 0);
    checkOutput({tag, "_r0_done"}, r0_done, 0);
    checkOutput({tag, "_r1_done"}, r1_done, 0);
    checkOutput({tag, "_cmd_en"}, mem_cmd_en, 0);
    checkOutput({tag, "_wr_en"}, mem_wr_en, 0);
    checkOutput({tag, "_rd_en"}, mem_rd_en, 0);
  endtask

  // In IDLE with calibration done: a lone requester wins, a tie goes to the one not granted last.
  task automatic arbitrate(output int winner);
    if (fReq[0] && fReq[1]) winner = 1 - lastGrant;
    else if (fReq[0])       winner = 0;
    else if (fReq[1])       winner = 1;
    else                    winner = -1;
    applyStimulus();
    #1;
    checkOutput("r0_ready", r0_ready, 32'(winner == 0));
    checkOutput("r1_ready", r1_ready, 32'(winner == 1));
    if (winner >= 0) lastGrant = winner;
  endtask

  // Runs the granted transaction. stallA/stallB are the full/empty cycles of the two MIG phases;
  // every stall cycle delays the rest of the transaction by one, so done lands at 3 + stalls.
  task automatic runTxn(input int w, input bit holdReq, input int stallA, input int stallB, input bit dropCalib);
    bit          we;
    int          wrCyc, cmdCyc, rdCyc, expDone;
    int unsigned key;
    logic [31:0] byteAddr, memVal, merged;
    we       = fWe[w];
    key      = 32'(fAddr[w]) >> 2;
    byteAddr = 32'(fAddr[w]) & 32'hFFFF_FFFC;
    if (!refMem.exists(key)) refMem[key] = $urandom;
    memVal   = refMem[key];
    if (we) begin
      wrCyc  = stallA + 1;
      cmdCyc = stallA + stallB + 2;
      rdCyc  = -1;
    end else begin
      wrCyc  = -1;
      cmdCyc = stallA + 1;
      rdCyc  = stallA + stallB + 2;
    end
    expDone = stallA + stallB + 3;
    tick();
    if (!holdReq) fReq[w] = 1'b0;
    for (int cyc = 1; cyc <= expDone; cyc++) begin
      if (dropCalib && cyc == 1) calib_done = 1'b0;
      mem_wr_full  = we && (cyc <= stallA);
      mem_cmd_full = we ? ((cyc >= stallA + 2) && (cyc <= stallA + stallB + 1)) : (cyc <= stallA);
      mem_rd_empty = !(!we && cyc == rdCyc);
      mem_rd_data  = (!we && cyc == rdCyc) ? memVal : $urandom;
      applyStimulus();
      #1;
      checkOutput("wr_en", mem_wr_en, 32'(cyc == wrCyc));
      checkOutput("cmd_en", mem_cmd_en, 32'(cyc == cmdCyc));
      checkOutput("rd_en", mem_rd_en, 32'(cyc == rdCyc));
      checkOutput("busy_r0_ready", r0_ready, 0);
      checkOutput("busy_r1_ready", r1_ready, 0);
      checkOutput("r0_done", r0_done, 32'(cyc == expDone && w == 0));
      checkOutput("r1_done", r1_done, 32'(cyc == expDone && w == 1));
      if (cyc == wrCyc) begin
        checkOutput("wr_data", mem_wr_data, fData[w]);
        checkOutput("wr_mask", mem_wr_mask, 32'(fMask[w]));
      end
      if (cyc == cmdCyc) begin
        checkOutput("cmd_instr", mem_cmd_instr, we ? 32'd0 : 32'd1);
        checkOutput("cmd_addr", mem_cmd_byte_addr, byteAddr);
        if (we) begin
          merged = memVal;
          for (int b = 0; b < 4; b++) begin
            if (!fMask[w][b]) merged[8*b +: 8] = fData[w][8*b +: 8];
          end
          refMem[key] = merged;
        end
      end
      if (!we && cyc == rdCyc) expRdata[w] = memVal;
      if (cyc == expDone) begin
        checkOutput("r0_rdata", r0_rdata, expRdata[0]);
        checkOutput("r1_rdata", r1_rdata, expRdata[1]);
      end
      tick();
    end
    mem_wr_full  = 1'b0;
    mem_cmd_full = 1'b0;
    mem_rd_empty = 1'b1;
  endtask

  // Absolute time bound so the bench always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    rst = 1'b1; calib_done = 1'b0;
    mem_cmd_full = 1'b0; mem_wr_full = 1'b0; mem_rd_empty = 1'b1;
    mem_wr_error = 1'b0; mem_rd_error = 1'b0; mem_rd_data = 32'h0;
    for (int r = 0; r < 2; r++) begin
      fReq[r] = 1'b0; fWe[r] = 1'b0; fAddr[r] = '0; fData[r] = '0; fMask[r] = '0;
    end
    applyStimulus();
    resetDut();

    // Reset values.
    #1;
    checkQuiet("reset");
    checkOutput("reset_instr", mem_cmd_instr, 0);
    checkOutput("reset_bl", mem_cmd_bl, 0);
    checkOutput("reset_addr", mem_cmd_byte_addr, 0);
    checkOutput("reset_wdata", mem_wr_data, 0);
    checkOutput("reset_wmask", mem_wr_mask, 0);
    checkOutput("reset_r0_rdata", r0_rdata, 0);
    checkOutput("reset_r1_rdata", r1_rdata, 0);
    checkOutput("reset_err", err, 0);

    // r0 write held off while uncalibrated, then runs once calibration completes.
    fReq[0] = 1'b1; fWe[0] = 1'b1; fAddr[0] = ADDR_W'(32'h13); fData[0] = 32'hDEADBEEF; fMask[0] = 4'h0;
    applyStimulus();
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("nocalib_r0_ready", r0_ready, 0);
    end
    calib_done = 1'b1;
    arbitrate(w);
    runTxn(w, 1'b0, 0, 0, 1'b0);
    checkOutput("write1_mem", refMem[32'h13 >> 2], 32'hDEADBEEF);

    // r1 read of 0x40 with the read FIFO empty for five cycles.
    refMem[32'h40 >> 2] = 32'h12345678;
    fReq[1] = 1'b1; fWe[1] = 1'b0; fAddr[1] = ADDR_W'(32'h40);
    arbitrate(w);
    runTxn(w, 1'b0, 0, 5, 1'b0);
    checkOutput("read1_r1_rdata", r1_rdata, 32'h12345678);

    // Both requesters held continuously: grants must alternate starting with r0.
    for (int r = 0; r < 2; r++) begin
      randomizeReq(r);
      fReq[r] = 1'b1;
    end
    for (int k = 0; k < 4; k++) begin
      arbitrate(w);
      checkOutput("grant_order", 32'(w), 32'(k % 2));
      runTxn(w, 1'b1, 0, 0, 1'b0);
      randomizeReq(w);
    end
    fReq[0] = 1'b0; fReq[1] = 1'b0;

    // Write with 3 cycles of wr_full and 2 of cmd_full: done arrives at cycle 8.
    fReq[0] = 1'b1; fWe[0] = 1'b1; fAddr[0] = ADDR_W'(32'h24); fData[0] = 32'hA5A5_0F0F; fMask[0] = 4'b0101;
    arbitrate(w);
    runTxn(w, 1'b0, 3, 2, 1'b0);

    // Reset while waiting for read data: back to IDLE with no done and cleared outputs.
    fReq[0] = 1'b1; fWe[0] = 1'b0; fAddr[0] = ADDR_W'(32'h80);
    arbitrate(w);
    tick();
    fReq[0] = 1'b0;
    applyStimulus();
    #1;
    checkOutput("rstrd_cmd_en", mem_cmd_en, 1);
    checkOutput("rstrd_instr", mem_cmd_instr, 1);
    tick();
    checkOutput("rstrd_wait_rd_en", mem_rd_en, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lastGrant = 1; expRdata[0] = 32'h0; expRdata[1] = 32'h0;
    mem_rd_empty = 1'b0; mem_rd_data = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkQuiet("post_reset");
      checkOutput("post_reset_addr", mem_cmd_byte_addr, 0);
      checkOutput("post_reset_r0_rdata", r0_rdata, 0);
      tick();
    end
    mem_rd_empty = 1'b1;
    fReq[0] = 1'b1; fWe[0] = 1'b1; fAddr[0] = ADDR_W'(32'h35); fData[0] = $urandom; fMask[0] = 4'h0;
    arbitrate(w);
    runTxn(w, 1'b0, 0, 0, 1'b0);

    // calib_done falls mid-transaction: it completes, then no further grant until it returns.
    fReq[1] = 1'b1; fWe[1] = 1'b1; fAddr[1] = ADDR_W'(32'h8); fData[1] = $urandom; fMask[1] = 4'h2;
    arbitrate(w);
    runTxn(w, 1'b0, 1, 0, 1'b1);
    fReq[0] = 1'b1; randomizeReq(0);
    applyStimulus();
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("nocalib2_r0_ready", r0_ready, 0);
      tick();
    end
    calib_done = 1'b1;
    fReq[0] = 1'b0;
    applyStimulus();

    // A single-cycle write error sets the sticky err flag; traffic keeps flowing.
    mem_wr_error = 1'b1;
    tick();
    mem_wr_error = 1'b0;
    #1;
    checkOutput("err_set", err, 1);
    fReq[1] = 1'b1; randomizeReq(1);
    arbitrate(w);
    runTxn(w, 1'b0, 0, 1, 1'b0);
    checkOutput("err_sticky", err, 1);
    mem_rd_error = 1'b1;
    tick();
    mem_rd_error = 1'b0;
    resetDut();
    #1;
    checkOutput("err_cleared", err, 0);
    mem_rd_error = 1'b1;
    tick();
    mem_rd_error = 1'b0;
    #1;
    checkOutput("err_rd_set", err, 1);

    // Randomized traffic: requesters come and go, losers keep their request until granted.
    for (int n = 0; n < 40; n++) begin
      for (int r = 0; r < 2; r++) begin
        if (!fReq[r]) begin
          randomizeReq(r);
          fReq[r] = 1'($urandom_range(0, 1));
        end
      end
      if (!fReq[0] && !fReq[1]) fReq[$urandom_range(0, 1)] = 1'b1;
      arbitrate(w);
      runTxn(w, 1'b0, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end
    fReq[0] = 1'b0; fReq[1] = 1'b0;
    applyStimulus();
    tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
